// File: rtl/uart_pkg.sv
// Shared definitions for the NANO-link UART transmit path: the default byte
// width, the bit period at 115200 baud on the 50 MHz clock, the arbiter state
// encoding and a small width helper used to size counters.
package uart_pkg;

    localparam int BITS_N_DEFAULT      = 8;
    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // $clog2 clamped to at least one bit so degenerate parameters still give
    // a legal vector width.
    function automatic int clogMin1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: starting at ptr_i and wrapping modulo
// N_REQ, returns the first requesting index and whether anyone requests.
// Holds no state so any arbiter can reuse it with its own pointer policy.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = clogMin1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             any_valid_o
);

    logic [PTR_W-1:0] candIdx;

    // Scan from the farthest offset back to offset 0 so the candidate
    // closest to the pointer overwrites everything behind it.
    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        candIdx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            candIdx = PTR_W'((int'(ptr_i) + k) % N_REQ);
            if (req_valid_i[candIdx]) begin
                winner_o    = candIdx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ message sources. A granted
// source keeps the serializer until its last byte (or the per-grant byte
// limit), after which an idle gap lets the NANO find the packet boundary.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int BITS_N        = BITS_N_DEFAULT,
    parameter int GAP_CLKS      = CLKS_PER_BIT_115200,
    parameter int MAX_PKT_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*BITS_N-1:0] req_data,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [BITS_N-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PTR_W = clogMin1(N_REQ);
    localparam int CNT_W = clogMin1(MAX_PKT_BYTES + 1);
    localparam int GAP_W = clogMin1(GAP_CLKS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(N_REQ - 1);

    arb_state_e       state_q,   state_d;
    logic [PTR_W-1:0] ptr_q,     ptr_d;
    logic [PTR_W-1:0] owner_q,   owner_d;
    logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
    logic [GAP_W-1:0] gapCnt_q,  gapCnt_d;

    logic [PTR_W-1:0]  pickIdx;
    logic              pickAny;
    logic [BITS_N-1:0] ownerData;
    logic              ownerValid;
    logic              ownerLast;
    logic              sending;
    logic              xfer;
    logic              limitHit;
    logic              pktDone;
    logic [PTR_W-1:0]  nextPtr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .winner_o    (pickIdx),
        .any_valid_o (pickAny)
    );

    // Route the current owner's byte, valid and last flag out of the request
    // buses; a constant-index mux keeps the selection free of width games.
    always_comb begin
        ownerData  = '0;
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                ownerData  = req_data[i*BITS_N +: BITS_N];
                ownerValid = req_valid[i];
                ownerLast  = req_last[i];
            end
        end
    end

    // Transfer qualification; reset forces everything quiet immediately so a
    // half-sent packet cannot leak another byte while rst is high.
    always_comb begin
        sending  = (state_q == SEND) && !rst;
        xfer     = sending && ownerValid && tx_ready;
        limitHit = (byteCnt_q == CNT_LAST);
        pktDone  = xfer && (ownerLast || limitHit);
        nextPtr  = (owner_q == PTR_TOP) ? '0 : owner_q + PTR_W'(1);
    end

    // Output decode: only the owner sees tx_ready, and only during SEND.
    always_comb begin
        req_ready = '0;
        grant     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sending && (owner_q == PTR_W'(i))) begin
                req_ready[i] = tx_ready;
                grant[i]     = 1'b1;
            end
        end
        tx_data  = sending ? ownerData : '0;
        tx_valid = sending && ownerValid;
        busy     = (state_q != IDLE) && !rst;
        overrun  = xfer && !ownerLast && limitHit;
    end

    // Next-state logic: arbitrate from IDLE, stay locked in SEND until the
    // packet ends or hits the byte limit, then sit out the gap.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        byteCnt_d = byteCnt_q;
        gapCnt_d  = gapCnt_q;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    state_d   = SEND;
                    owner_d   = pickIdx;
                    byteCnt_d = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    byteCnt_d = byteCnt_q + CNT_W'(1);
                end
                if (pktDone) begin
                    ptr_d    = nextPtr;
                    gapCnt_d = '0;
                    if (GAP_CLKS == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset back to an idle, pointer-zero
    // arbiter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            byteCnt_q <= '0;
            gapCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            byteCnt_q <= byteCnt_d;
            gapCnt_q  <= gapCnt_d;
        end
    end

    // Structural sanity: never more than one owner, and an overrun is always
    // tied to an actual byte transfer.
    assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    assert property (@(posedge clk) disable iff (rst) overrun |-> (tx_valid && tx_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues drive the
// request side, a simple uart_tx model drops ready for a programmable number
// of cycles after each byte, and a monitor logs every transfer.
module tb_uart_tx_arbiter;

    localparam int N = 3;
    localparam int W = 8;
    localparam int GAPC = 434;
    localparam int MAXB = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           overrun;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    logic [8:0]   srcQ [N][$];
    logic [W-1:0] txLog[$];
    logic [N-1:0] grantLog[$];
    int           cycLog[$];
    int           ovCnt = 0;
    logic [W-1:0] ovData = '0;
    logic [N-1:0] hsPend = '0;
    logic         txHs = 1'b0;
    int           holdCycles = 2;
    int           busyCnt = 0;
    logic         stallForce = 1'b0;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .BITS_N(W), .GAP_CLKS(GAPC), .MAX_PKT_BYTES(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant), .busy(busy),
        .overrun(overrun)
    );

    assign tx_ready = (busyCnt == 0) && !stallForce;

    // Monitor: sample handshakes mid-cycle and log each byte handed to uart_tx.
    always @(negedge clk) begin
        cycle++;
        hsPend = req_valid & req_ready;
        txHs   = tx_valid & tx_ready;
        if (txHs) begin
            txLog.push_back(tx_data);
            grantLog.push_back(grant);
            cycLog.push_back(cycle);
        end
        if (overrun === 1'b1) begin
            ovCnt++;
            ovData = tx_data;
        end
    end

    // uart_tx model: ready drops for holdCycles after every accepted byte.
    always @(posedge clk) begin
        if (rst) busyCnt <= 0;
        else if (txHs) busyCnt <= holdCycles;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end

    // Source model: pop accepted bytes and present each queue head.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hsPend[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            if (srcQ[i].size() > 0) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i*W +: W]} = srcQ[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearLogs();
        txLog.delete();
        grantLog.delete();
        cycLog.delete();
        ovCnt = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) srcQ[i].delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic waitLog(input int n, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            if (txLog.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (txLog.size() >= n) ok = 1'b1;
    endtask

    task automatic waitIdle(input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (busy === 1'b0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        srcQ[0].push_back({1'b1, 8'h99});
        tick(3);
        checks++; if ({grant, tx_valid, busy, overrun} !== '0) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {grant, tx_valid, busy, overrun}); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", tx_data); end
        doReset();
    endtask

    task automatic test_single_packet();
        bit ok;
        doReset();
        holdCycles = 10 * 434;
        clearLogs();
        srcQ[0].push_back({1'b0, 8'hA5});
        srcQ[0].push_back({1'b1, 8'h3C});
        waitLog(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_first_timeout: got %0d bytes expected 1", txLog.size()); end
        if (ok) begin
            checks++; if (txLog[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_byte0: got %h expected a5", txLog[0]); end
            checks++; if (grantLog[0] !== 3'b001) begin errors++; $display("[TB] FAIL single_grant0: got %b expected 001", grantLog[0]); end
        end
        tick(100);
        checks++; if ({grant, busy, tx_valid} !== 5'b00111) begin errors++; $display("[TB] FAIL single_hold: got %b expected 00111", {grant, busy, tx_valid}); end
        checks++; if (tx_data !== 8'h3C) begin errors++; $display("[TB] FAIL single_stall_data: got %h expected 3c", tx_data); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL single_stall_ready: got %b expected 000", req_ready); end
        waitLog(2, 6000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_second_timeout: got %0d bytes expected 2", txLog.size()); end
        if (ok) begin
            checks++; if (txLog[1] !== 8'h3C) begin errors++; $display("[TB] FAIL single_byte1: got %h expected 3c", txLog[1]); end
            checks++; if (grantLog[1] !== 3'b001) begin errors++; $display("[TB] FAIL single_grant1: got %b expected 001", grantLog[1]); end
            checks++; if ({busy, grant} !== 4'b1000) begin errors++; $display("[TB] FAIL gap_entry: got %b expected 1000", {busy, grant}); end
            tick(433);
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_last_cycle: got busy=%b expected 1", busy); end
            tick(1);
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_release: got busy=%b expected 0", busy); end
        end
        holdCycles = 2;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [W-1:0] expData [3];
        logic [N-1:0] expGrant [3];
        expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h33;
        expGrant[0] = 3'b001; expGrant[1] = 3'b010; expGrant[2] = 3'b100;
        doReset();
        for (int round = 0; round < 2; round++) begin
            waitIdle(2000, ok);
            clearLogs();
            srcQ[0].push_back({1'b1, 8'h11});
            srcQ[1].push_back({1'b1, 8'h22});
            srcQ[2].push_back({1'b1, 8'h33});
            waitLog(3, 3000, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout round %0d: got %0d bytes expected 3", round, txLog.size()); end
            if (ok) begin
                for (int i = 0; i < 3; i++) begin
                    checks++; if (txLog[i] !== expData[i] || grantLog[i] !== expGrant[i]) begin errors++; $display("[TB] FAIL rr_order round %0d slot %0d: got %h/%b expected %h/%b", round, i, txLog[i], grantLog[i], expData[i], expGrant[i]); end
                end
            end
        end
    endtask

    task automatic test_no_interleave();
        bit ok;
        bit leak;
        int budget;
        logic [W-1:0] expData [4];
        expData[0] = 8'h01; expData[1] = 8'h02; expData[2] = 8'h03; expData[3] = 8'h77;
        waitIdle(2000, ok);
        clearLogs();
        srcQ[0].push_back({1'b0, 8'h01});
        srcQ[0].push_back({1'b0, 8'h02});
        srcQ[0].push_back({1'b1, 8'h03});
        waitLog(1, 100, ok);
        srcQ[1].push_back({1'b1, 8'h77});
        leak = 1'b0;
        budget = 3000;
        while (txLog.size() < 4 && budget > 0) begin
            if (req_ready[1] === 1'b1 && grant[1] !== 1'b1) leak = 1'b1;
            tick(1);
            budget--;
        end
        checks++; if (txLog.size() < 4) begin errors++; $display("[TB] FAIL nointer_timeout: got %0d bytes expected 4", txLog.size()); end
        checks++; if (leak) begin errors++; $display("[TB] FAIL nointer_ready1: got ready before grant expected none"); end
        if (txLog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (txLog[i] !== expData[i]) begin errors++; $display("[TB] FAIL nointer_seq %0d: got %h expected %h", i, txLog[i], expData[i]); end
            end
            checks++; if (cycLog[3] - cycLog[2] != GAPC + 2) begin errors++; $display("[TB] FAIL nointer_gap: got %0d expected %0d", cycLog[3] - cycLog[2], GAPC + 2); end
            checks++; if (grantLog[3] !== 3'b010) begin errors++; $display("[TB] FAIL nointer_grant: got %b expected 010", grantLog[3]); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        waitIdle(2000, ok);
        clearLogs();
        for (int k = 0; k <= 16; k++) srcQ[2].push_back({1'b0, 8'(k)});
        waitLog(17, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovr_timeout: got %0d bytes expected 17", txLog.size()); end
        if (ok) begin
            for (int k = 0; k <= 16; k++) begin
                checks++; if (txLog[k] !== 8'(k)) begin errors++; $display("[TB] FAIL ovr_byte %0d: got %h expected %h", k, txLog[k], 8'(k)); end
            end
            checks++; if (cycLog[16] - cycLog[15] != GAPC + 2) begin errors++; $display("[TB] FAIL ovr_regrant_gap: got %0d expected %0d", cycLog[16] - cycLog[15], GAPC + 2); end
            checks++; if (grantLog[16] !== 3'b100) begin errors++; $display("[TB] FAIL ovr_regrant: got %b expected 100", grantLog[16]); end
        end
        checks++; if (ovCnt != 1) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 1", ovCnt); end
        checks++; if (ovData !== 8'h0F) begin errors++; $display("[TB] FAIL ovr_byte_at_pulse: got %h expected 0f", ovData); end
        tick(5);
        checks++; if ({grant, tx_valid, busy} !== 5'b10001) begin errors++; $display("[TB] FAIL owner_stall: got %b expected 10001", {grant, tx_valid, busy}); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        doReset();
        clearLogs();
        srcQ[0].push_back({1'b1, 8'h55});
        waitLog(1, 100, ok);
        waitIdle(2000, ok);
        clearLogs();
        srcQ[1].push_back({1'b0, 8'h66});
        srcQ[1].push_back({1'b1, 8'h67});
        waitLog(1, 100, ok);
        checks++; if (!ok || txLog[0] !== 8'h66) begin errors++; $display("[TB] FAIL midrst_first: got %0d bytes expected byte 66", txLog.size()); end
        rst = 1'b1;
        for (int i = 0; i < N; i++) srcQ[i].delete();
        tick(1);
        checks++; if ({grant, tx_valid, busy} !== 5'b00000) begin errors++; $display("[TB] FAIL midrst_outputs: got %b expected 00000", {grant, tx_valid, busy}); end
        rst = 1'b0;
        clearLogs();
        srcQ[0].push_back({1'b1, 8'hA0});
        srcQ[1].push_back({1'b1, 8'hB1});
        waitLog(2, 2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_timeout: got %0d bytes expected 2", txLog.size()); end
        if (ok) begin
            checks++; if (txLog[0] !== 8'hA0 || grantLog[0] !== 3'b001) begin errors++; $display("[TB] FAIL midrst_ptr0: got %h/%b expected a0/001", txLog[0], grantLog[0]); end
            checks++; if (txLog[1] !== 8'hB1) begin errors++; $display("[TB] FAIL midrst_next: got %h expected b1", txLog[1]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        waitIdle(2000, ok);
        clearLogs();
        stallForce = 1'b1;
        srcQ[0].push_back({1'b1, 8'hC3});
        tick(3);
        bad = 0;
        repeat (50) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'hC3 || req_ready !== 3'b000 || grant !== 3'b001) bad++;
            tick(1);
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d bad cycles expected 0", bad); end
        checks++; if (txLog.size() != 0) begin errors++; $display("[TB] FAIL stall_no_xfer: got %0d bytes expected 0", txLog.size()); end
        stallForce = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001 || tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got %b/%b expected 001/1", req_ready, tx_valid); end
        tick(1);
        checks++; if (txLog.size() != 1 || txLog[0] !== 8'hC3) begin errors++; $display("[TB] FAIL stall_xfer: got %0d bytes expected 1 byte c3", txLog.size()); end
    endtask

    initial begin
        bit ok;
        $display("[TB] starting uart_tx_arbiter bench");
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_overrun();
        test_mid_reset();
        test_stall();
        waitIdle(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL final_idle: got busy=%b expected 0", busy); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
